// File: rtl/hex_scan_scheduler_if.sv
// ---------------------------------------------------------------------------
// hex_scan_scheduler_if
// Purpose : Bundles the load handshake, blanking control and display outputs
//           of hex_scan_scheduler into one port.
// Signals :
//   LOAD_VALID  master->slave  LOAD_DATA is offered
//   LOAD_READY  slave->master  shadow register free (transfer on VALID&READY)
//   LOAD_DATA   master->slave  4*NUM_DIGITS, nibble i drives digit i
//   BLANK       master->slave  NUM_DIGITS, 1 forces a digit dark at its write
//   HEX_ALL     slave->master  7*NUM_DIGITS, active-low {g,f,e,d,c,b,a}
//   FRAME_DONE  slave->master  one-cycle pulse at the end of each frame
// ---------------------------------------------------------------------------
interface hex_scan_scheduler_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    LOAD_VALID;
  logic                    LOAD_READY;
  logic [4*NUM_DIGITS-1:0] LOAD_DATA;
  logic [NUM_DIGITS-1:0]   BLANK;
  logic [7*NUM_DIGITS-1:0] HEX_ALL;
  logic                    FRAME_DONE;

  // Source side: the user/switch logic.
  modport master (
    output LOAD_VALID, LOAD_DATA, BLANK,
    input  LOAD_READY, HEX_ALL, FRAME_DONE
  );

  // Sink side: the scheduler itself.
  modport slave (
    input  LOAD_VALID, LOAD_DATA, BLANK,
    output LOAD_READY, HEX_ALL, FRAME_DONE
  );
endinterface

// File: rtl/hex_scan_scheduler.sv
// ---------------------------------------------------------------------------
// hex_scan_scheduler
// Purpose : Time-slot scheduler that shares a single hex-to-7-segment decoder
//           among NUM_DIGITS displays. A value is loaded into a shadow
//           register through a valid/ready handshake and only becomes active
//           at a frame boundary, so one frame never mixes old and new digits.
// Ports   :
//   CLOCK_50  in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset (synchronous release upstream)
//   bus       slave modport of hex_scan_scheduler_if (load handshake, BLANK,
//             HEX_ALL segment outputs, FRAME_DONE pulse)
// Parameters:
//   NUM_DIGITS  displays scheduled (>=1); must match the interface parameter
//   TICK_DIV    cycles spent waiting in each digit slot (>=1)
// ---------------------------------------------------------------------------
module hex_scan_scheduler #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  hex_scan_scheduler_if.slave   bus
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_APPLY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic                    r_pending;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_frame_done;
  logic [6:0]              r_hex [NUM_DIGITS];

  logic                    w_accept;
  logic                    w_apply;
  logic                    w_cnt_last;
  logic                    w_last_digit;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [6:0]              w_seg;

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Split the active value into per-digit nibbles so the shared decoder
  // input is a plain array lookup by slot index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nib[gi]                 = r_active[4*gi +: 4];
      assign bus.HEX_ALL[7*gi +: 7]    = r_hex[gi];
    end
  endgenerate

  assign w_seg        = seg_decode(w_nib[r_idx]);
  assign w_cnt_last   = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Accepting and applying are mutually exclusive: accept needs pending=0,
  // apply needs pending=1. A load accepted during APPLY therefore waits a
  // whole frame; there is deliberately no bypass into r_active.
  assign w_accept       = bus.LOAD_VALID & ~r_pending;
  assign w_apply        = (r_state == ST_APPLY) & r_pending;
  assign bus.LOAD_READY = ~r_pending;
  assign bus.FRAME_DONE = r_frame_done;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_APPLY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_APPLY: w_state_next = ST_WAIT;
      ST_WAIT:  if (w_cnt_last) w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = w_last_digit ? ST_APPLY : ST_WAIT;
      default:  w_state_next = ST_APPLY;
    endcase
  end

  // Shadow / active handoff.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else if (w_apply) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_shadow  <= bus.LOAD_DATA;
      r_pending <= 1'b1;
    end
  end

  // Slot index and tick counter. The index only returns to 0 in APPLY, so a
  // non-power-of-two digit count never relies on natural wrap-around.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_APPLY: begin
          r_idx <= '0;
          r_cnt <= '0;
        end
        ST_WAIT: begin
          r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
        ST_WRITE: begin
          if (w_last_digit) begin
            r_frame_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_idx <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Segment registers: only the slice of the digit being written changes,
  // and BLANK is sampled at that moment, so mid-frame BLANK changes only
  // reach digits not yet written in the current frame.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_hex[i] <= 7'h7F;
      end
    end else if (r_state == ST_WRITE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_idx == IDX_W'(i)) begin
          r_hex[i] <= bus.BLANK[i] ? 7'h7F : w_seg;
        end
      end
    end
  end

endmodule
